pwm_scheduler: RTL and testbench
================================

// Module: pwm_scheduler
// PURPOSE
//   Applies the SPI-written PWM configuration (output enables, PWM enables, duty) to
//   16 output channels. Runs a prescaled 8-bit PWM period counter. Double-buffers the
//   configuration so new values take effect only at a period boundary, which keeps
//   every output free of glitches. Sits between the SPI register file and the chip pins.
// PARAMETERS
//   CLK_DIV  3000  i_clk cycles per PWM count tick; legal 1..4095 (1 = tick every cycle)
//   DIV_W    12    prescaler width; must hold CLK_DIV-1
// PORTS
//   i_clk          in   1   system clock
//   i_rst_n        in   1   reset, asynchronous, active-low
//   i_en_out       in   16  output enables {15_8,7_0}, held stable by SPI block
//   i_en_pwm       in   16  per-channel PWM mode select (1 = PWM, 0 = static high)
//   i_duty         in   8   duty cycle, 0..255
//   i_cfg_stb      in   1   1-cycle pulse: a config register was written
//   o_out          out  16  channel outputs, registered
//   o_period_start out  1   1-cycle pulse when the counter wraps 255->0
//   o_pending      out  1   a config update is waiting for the next period boundary
//   o_running      out  1   state == RUN
// BEHAVIOUR
//   Reset: o_out=0, o_period_start=0, o_pending=0, o_running=0. Prescaler=0, cnt=0.
//     Shadows act_en_out/act_en_pwm/act_duty=0. State=IDLE.
//   Tick: prescaler counts 0..CLK_DIV-1 in RUN. tick=1 on the cycle it equals CLK_DIV-1,
//     then it returns to 0. On tick, cnt (8b) increments and wraps 255->0; that wrap
//     cycle is a "boundary". o_period_start is registered, high for 1 cycle after it.
//   States:
//     IDLE: prescaler and cnt are held at 0. i_cfg_stb loads the shadows from the inputs
//       next cycle. If the loaded en_out != 0 -> RUN (cnt starts at 0), else stay IDLE.
//     RUN: i_cfg_stb sets pending=1. At a boundary with pending=1 (or i_cfg_stb in that
//       same cycle), the shadows load from the inputs as sampled in that cycle, and pending
//       clears. If the new act_en_out == 0 -> IDLE (prescaler, cnt cleared); else stay RUN.
//   Strobes while pending=1 are absorbed: the last value wins and no extra latency is added.
//   Strobe on the exact boundary cycle: update applied at that boundary, pending stays 0.
//   Channel i, computed combinationally and registered into o_out (1-cycle latency):
//     pwm_hi = (act_duty == 8'hFF) ? 1 : (cnt < act_duty)
//     o_out[i] = act_en_out[i] & (act_en_pwm[i] ? pwm_hi : 1)
//   Duty 0 -> constant low; duty 255 -> constant high; duty D -> high for D of 256 counts.
//   In IDLE, o_out = act_en_out & ~act_en_pwm & 0 = 0, since IDLE implies act_en_out=0.
//   i_duty and the enables are only ever sampled on a shadow load; changes between loads
//     are ignored.
//   Async reset mid-period: all state and outputs return to reset values immediately.
//   Counters use modular arithmetic only; there are no saturating paths.
// TESTING
//   T1 reset: assert i_rst_n=0 mid-RUN -> o_out=0, o_running=0, o_pending=0 same cycle.
//   T2 CLK_DIV=4, en_out=16'h0001, en_pwm=16'h0001, duty=64, strobe in IDLE
//      -> RUN; o_out[0] high 64*4 of every 1024 cycles; o_period_start every 1024 cycles.
//   T3 static: en_out=16'hFFFF, en_pwm=0 -> o_out=16'hFFFF constant, 1 cycle after load.
//   T4 duty 0 and 255 with en_pwm=1 -> output constant low / constant high, no pulses.
//   T5 RUN duty=64, then write duty=192 mid-period -> o_pending=1; old duty finishes the
//      period; new duty starts at cnt=0; o_pending=0 after the boundary.
//   T6 RUN, write en_out=0 -> outputs unchanged until the boundary, then 0; o_running=0;
//      strobe coincident with the boundary is applied at that boundary.

Source files
------------

// File: rtl/pwm_scheduler_if.sv
// Configuration and status bundle between the SPI register file and the PWM scheduler.
interface pwm_scheduler_if;
  logic [15:0] i_en_out;
  logic [15:0] i_en_pwm;
  logic [7:0]  i_duty;
  logic        i_cfg_stb;
  logic [15:0] o_out;
  logic        o_period_start;
  logic        o_pending;
  logic        o_running;

  // Register-file side: writes configuration, observes status.
  modport master (
    output i_en_out, i_en_pwm, i_duty, i_cfg_stb,
    input  o_out, o_period_start, o_pending, o_running
  );

  // Scheduler side.
  modport slave (
    input  i_en_out, i_en_pwm, i_duty, i_cfg_stb,
    output o_out, o_period_start, o_pending, o_running
  );
endinterface

// File: rtl/pwm_scheduler.sv
// 16-channel PWM scheduler: prescaled 8-bit period counter with double-buffered
// configuration that only changes at period boundaries, keeping outputs glitch-free.
module pwm_scheduler #(
  parameter int unsigned CLK_DIV = 3000,
  parameter int unsigned DIV_W   = 12
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pwm_scheduler_if.slave  bus
);

  localparam int unsigned CH_N  = 16;
  localparam int unsigned CNT_W = 8;

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = '1;
  localparam logic [CNT_W-1:0] DUTY_FULL  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_N-1:0]  act_en_out_q, act_en_out_d;
  logic [CH_N-1:0]  act_en_pwm_q, act_en_pwm_d;
  logic [CNT_W-1:0] act_duty_q, act_duty_d;
  logic             pending_q, pending_d;
  logic [CH_N-1:0]  out_q, out_d;
  logic             period_start_q;

  logic tick;
  logic boundary;
  logic pwm_hi;

  // Prescaler tick and end-of-period detection (only meaningful while running).
  always_comb begin
    tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
    boundary = tick && (cnt_q == CNT_LAST);
  end

  // Next-state logic: counters, shadow loads and pending-update tracking.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    act_en_out_d = act_en_out_q;
    act_en_pwm_d = act_en_pwm_q;
    act_duty_d   = act_duty_q;
    pending_d    = pending_q;

    case (state_q)
      IDLE: begin
        presc_d   = '0;
        cnt_d     = '0;
        pending_d = 1'b0;
        if (bus.i_cfg_stb) begin
          act_en_out_d = bus.i_en_out;
          act_en_pwm_d = bus.i_en_pwm;
          act_duty_d   = bus.i_duty;
          if (bus.i_en_out != '0) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        presc_d = tick ? '0 : presc_q + DIV_W'(1);
        if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (bus.i_cfg_stb) begin
          pending_d = 1'b1;
        end
        // A strobe on the boundary itself is applied immediately, never left pending.
        if (boundary && (pending_q || bus.i_cfg_stb)) begin
          act_en_out_d = bus.i_en_out;
          act_en_pwm_d = bus.i_en_pwm;
          act_duty_d   = bus.i_duty;
          pending_d    = 1'b0;
          if (bus.i_en_out == '0) begin
            state_d = IDLE;
            presc_d = '0;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Channel outputs from the active shadow and the current count.
  always_comb begin
    pwm_hi = (act_duty_q == DUTY_FULL) || (cnt_q < act_duty_q);
    out_d  = act_en_out_q & (~act_en_pwm_q | {CH_N{pwm_hi}});
  end

  // State, shadows and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      cnt_q          <= '0;
      act_en_out_q   <= '0;
      act_en_pwm_q   <= '0;
      act_duty_q     <= '0;
      pending_q      <= 1'b0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      act_en_out_q   <= act_en_out_d;
      act_en_pwm_q   <= act_en_pwm_d;
      act_duty_q     <= act_duty_d;
      pending_q      <= pending_d;
      out_q          <= out_d;
      period_start_q <= boundary;
    end
  end

  // Status outputs are flop outputs driven straight to the bus.
  assign bus.o_out          = out_q;
  assign bus.o_period_start = period_start_q;
  assign bus.o_pending      = pending_q;
  assign bus.o_running      = (state_q == RUN);

endmodule

// File: tb/tb_pwm_scheduler.sv
// Self-checking bench for pwm_scheduler: directed scenarios plus randomized
// configuration traffic checked against a behavioural period-arithmetic model.
module tb_pwm_scheduler;

  localparam int unsigned DIV    = 4;
  localparam int unsigned PERIOD = DIV * 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pwm_scheduler_if bus ();

  pwm_scheduler #(
    .CLK_DIV (DIV),
    .DIV_W   (12)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: running flag, cycles elapsed since RUN began, shadows.
  bit              m_run;
  int unsigned     m_rc;
  bit              m_pend;
  logic [15:0]     m_eo, m_ep;
  logic [7:0]      m_du;
  logic [15:0]     e_out;
  bit              e_ps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_out(input logic [15:0] eo, input logic [15:0] ep,
                                            input logic [7:0] du, input logic [7:0] cnt);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (eo[i]) r[i] = ep[i] ? ((du == 8'd255) || (cnt < du)) : 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_run = 0; m_rc = 0; m_pend = 0;
    m_eo = '0; m_ep = '0; m_du = '0;
    e_out = '0; e_ps = 0;
  endtask

  task automatic model_load();
    m_eo = bus.i_en_out;
    m_ep = bus.i_en_pwm;
    m_du = bus.i_duty;
  endtask

  task automatic model_step();
    logic [7:0] cnt;
    bit bnd;
    cnt   = 8'((m_rc / DIV) % 256);
    bnd   = m_run && (((m_rc + 1) % PERIOD) == 0);
    e_out = model_out(m_eo, m_ep, m_du, cnt);
    e_ps  = bnd;
    if (!m_run) begin
      if (bus.i_cfg_stb) begin
        model_load();
        if (bus.i_en_out != 16'h0) begin
          m_run = 1;
          m_rc  = 0;
        end
      end
    end else begin
      m_rc = m_rc + 1;
      if (bnd && (m_pend || bus.i_cfg_stb)) begin
        model_load();
        m_pend = 0;
        if (m_eo == 16'h0) begin
          m_run = 0;
          m_rc  = 0;
        end
      end else if (bus.i_cfg_stb) begin
        m_pend = 1;
      end
    end
  endtask

  // Model advance on each active edge, using the inputs the DUT samples.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("out",          32'(bus.o_out),          32'(e_out));
        check("period_start", 32'(bus.o_period_start), 32'(e_ps));
        check("pending",      32'(bus.o_pending),      32'(m_pend));
        check("running",      32'(bus.o_running),      32'(m_run));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] du);
    bus.i_en_out  = eo;
    bus.i_en_pwm  = ep;
    bus.i_duty    = du;
    bus.i_cfg_stb = 1'b1;
    cyc(1);
    bus.i_cfg_stb = 1'b0;
  endtask

  // Returns in the cycle where o_period_start is high (bounded wait).
  task automatic wait_ps();
    bit found;
    found = 0;
    for (int k = 0; k < 3 * int'(PERIOD) && !found; k++) begin
      cyc(1);
      if (bus.o_period_start) found = 1;
    end
    check("period_start_seen", 32'(found), 32'd1);
  endtask

  task automatic count_hi0(output int hi, output int ps);
    hi = 0;
    ps = 0;
    repeat (PERIOD) begin
      cyc(1);
      hi += int'(bus.o_out[0]);
      ps += int'(bus.o_period_start);
    end
  endtask

  initial begin
    int hi, ps, gap, bad;
    int unsigned r;
    bus.i_en_out  = '0;
    bus.i_en_pwm  = '0;
    bus.i_duty    = '0;
    bus.i_cfg_stb = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    check("reset_out",     32'(bus.o_out),          32'h0);
    check("reset_running", 32'(bus.o_running),      32'h0);
    check("reset_pending", 32'(bus.o_pending),      32'h0);
    check("reset_ps",      32'(bus.o_period_start), 32'h0);

    // Basic PWM: duty 64 on channel 0.
    strobe(16'h0001, 16'h0001, 8'd64);
    check("t2_running", 32'(bus.o_running), 32'd1);
    count_hi0(hi, ps);
    check("t2_high_count", 32'(hi), 32'd256);
    check("t2_ps_count",   32'(ps), 32'd1);
    wait_ps();
    gap = 0;
    for (int k = 0; k < 2 * int'(PERIOD); k++) begin
      cyc(1);
      gap++;
      if (bus.o_period_start) break;
    end
    check("t2_ps_interval", 32'(gap), 32'(PERIOD));

    // Static high on all channels, one cycle after the shadow load.
    cyc(50);
    strobe(16'hFFFF, 16'h0000, 8'd10);
    check("t3_pending", 32'(bus.o_pending), 32'd1);
    wait_ps();
    check("t3_out_at_load", 32'(bus.o_out), 32'h0000);
    cyc(1);
    check("t3_out_after", 32'(bus.o_out), 32'hFFFF);
    bad = 0;
    repeat (300) begin
      cyc(1);
      if (bus.o_out !== 16'hFFFF) bad++;
    end
    check("t3_constant", 32'(bad), 32'd0);

    // Duty 0 and 255 extremes.
    strobe(16'hFFFF, 16'hFFFF, 8'd0);
    wait_ps();
    cyc(1);
    bad = 0;
    repeat (PERIOD) begin
      cyc(1);
      if (bus.o_out !== 16'h0000) bad++;
    end
    check("t4_duty0_low", 32'(bad), 32'd0);
    strobe(16'hFFFF, 16'hFFFF, 8'd255);
    wait_ps();
    cyc(1);
    bad = 0;
    repeat (PERIOD) begin
      cyc(1);
      if (bus.o_out !== 16'hFFFF) bad++;
    end
    check("t4_duty255_high", 32'(bad), 32'd0);

    // Mid-period duty change; back-to-back strobes, last one wins.
    strobe(16'h0001, 16'h0001, 8'd64);
    wait_ps();
    cyc(101);
    strobe(16'h0001, 16'h0001, 8'd200);
    check("t5_pending_set", 32'(bus.o_pending), 32'd1);
    cyc(10);
    strobe(16'h0001, 16'h0001, 8'd192);
    check("t5_pending_held", 32'(bus.o_pending), 32'd1);
    wait_ps();
    check("t5_pending_clear", 32'(bus.o_pending), 32'd0);
    count_hi0(hi, ps);
    check("t5_high_count", 32'(hi), 32'd768);

    // Disable mid-period: holds until the boundary, then idle.
    cyc(200);
    strobe(16'h0000, 16'h0001, 8'd192);
    check("t6_still_running", 32'(bus.o_running), 32'd1);
    wait_ps();
    check("t6_idle", 32'(bus.o_running), 32'd0);
    cyc(1);
    check("t6_out_zero", 32'(bus.o_out), 32'h0);

    // Strobe exactly on the boundary cycle.
    strobe(16'h0001, 16'h0001, 8'd64);
    wait_ps();
    cyc(int'(PERIOD) - 1);
    strobe(16'h0000, 16'h0000, 8'd0);
    check("t6_coinc_ps",      32'(bus.o_period_start), 32'd1);
    check("t6_coinc_running", 32'(bus.o_running),      32'd0);
    check("t6_coinc_pending", 32'(bus.o_pending),      32'd0);

    // Async reset mid-run with an update pending.
    strobe(16'hFFFF, 16'h0000, 8'd0);
    cyc(50);
    strobe(16'h00FF, 16'h0000, 8'd0);
    chk_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_out",     32'(bus.o_out),     32'h0);
    check("t1_running", 32'(bus.o_running), 32'h0);
    check("t1_pending", 32'(bus.o_pending), 32'h0);
    cyc(2);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Randomized configuration traffic against the model.
    repeat (40000) begin
      r = $urandom_range(0, 399);
      if (r < 50) begin
        bus.i_en_out = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        bus.i_en_pwm = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       bus.i_duty = 8'd0;
          1:       bus.i_duty = 8'd255;
          default: bus.i_duty = 8'($urandom);
        endcase
      end
      bus.i_cfg_stb = (r < 3);
      cyc(1);
    end
    bus.i_cfg_stb = 1'b0;
    cyc(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
